// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Hazard and memory-wait control for a five-stage in-order pipeline.
//   Detects load-use hazards between EX and ID, flushes IF/ID on a taken
//   branch, freezes the whole pipeline while a data-memory access waits for
//   its acknowledge, and locks into an error state if the acknowledge never
//   arrives within TIMEOUT wait cycles.
//
// Ports
//   clk_i              : clock, all state on the rising edge
//   rst_i              : asynchronous active-low reset
//   EX_MemRead_i       : EX instruction is a load
//   EX_Rd_i            : EX destination register
//   ID_Rs1_i/ID_Rs2_i  : ID source registers
//   ID_Rs1Used_i/ID_Rs2Used_i : ID source fields actually read
//   ID_BranchTaken_i   : branch/jump in ID resolved taken
//   MEM_Req_i          : MEM stage needs data memory
//   DMem_Ack_i         : data memory completes current access
//   DMem_Valid_o       : request valid toward data memory
//   PCWrite_o          : PC update enable
//   IF_ID_Write_o      : IF/ID register write enable
//   ID_EX_NoOp_o       : inject a bubble into ID/EX
//   IF_ID_Flush_o      : flush IF/ID (taken branch)
//   Freeze_o           : whole-pipeline freeze (memory wait / error)
//   StallCount_o       : saturating count of cycles with PCWrite_o low
//   Timeout_o          : sticky memory-timeout error
module pipeline_stall_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_Rd_i,
  input  logic [4:0]  ID_Rs1_i,
  input  logic [4:0]  ID_Rs2_i,
  input  logic        ID_Rs1Used_i,
  input  logic        ID_Rs2Used_i,
  input  logic        ID_BranchTaken_i,
  input  logic        MEM_Req_i,
  input  logic        DMem_Ack_i,
  output logic        DMem_Valid_o,
  output logic        PCWrite_o,
  output logic        IF_ID_Write_o,
  output logic        ID_EX_NoOp_o,
  output logic        IF_ID_Flush_o,
  output logic        Freeze_o,
  output logic [15:0] StallCount_o,
  output logic        Timeout_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_q, timeout_d;

  logic        load_use_s;
  logic [8:0]  wait_inc_s;
  logic        pc_write_s;
  logic        if_id_write_s;
  logic        id_ex_noop_s;
  logic        if_id_flush_s;
  logic        freeze_s;
  logic        dmem_valid_s;

  // Load-use hazard: only a read source field can collide, and x0 never does.
  always_comb begin
    load_use_s = EX_MemRead_i & (EX_Rd_i != 5'd0) &
                 ((ID_Rs1Used_i & (EX_Rd_i == ID_Rs1_i)) |
                  (ID_Rs2Used_i & (EX_Rd_i == ID_Rs2_i)));
  end

  // Next-state and pipeline control; freeze beats load-use, load-use beats flush.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    wait_inc_s    = {1'b0, wait_cnt_q} + 9'd1;
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    id_ex_noop_s  = 1'b0;
    if_id_flush_s = 1'b0;
    freeze_s      = 1'b0;
    dmem_valid_s  = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        // In MEM_WAIT the request stays asserted regardless of MEM_Req_i.
        if (state_q == ST_MEM_WAIT) begin
          dmem_valid_s = 1'b1;
        end else begin
          dmem_valid_s = MEM_Req_i;
        end

        if (dmem_valid_s && !DMem_Ack_i) begin
          // Waiting on memory: everything holds, hazard inputs are ignored.
          freeze_s      = 1'b1;
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          if (state_q == ST_RUN) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = 8'd0;
          end else if (wait_inc_s >= TIMEOUT_C) begin
            state_d    = ST_ERROR;
            wait_cnt_d = wait_inc_s[7:0];
            timeout_d  = 1'b1;
          end else begin
            wait_cnt_d = wait_inc_s[7:0];
          end
        end else begin
          // Normal flow (also the ack cycle of a wait): hazard logic as in RUN.
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
          if (load_use_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_noop_s  = 1'b1;
          end else if (ID_BranchTaken_i) begin
            if_id_flush_s = 1'b1;
          end else begin
            if_id_flush_s = 1'b0;
          end
        end
      end
      ST_ERROR: begin
        // Terminal until reset.
        freeze_s      = 1'b1;
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
        timeout_d     = 1'b1;
      end
      default: begin
        // Unreachable encoding: fail safe into the error lock.
        state_d       = ST_ERROR;
        freeze_s      = 1'b1;
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
        timeout_d     = 1'b1;
      end
    endcase
  end

  // Stall counter saturates at all-ones instead of wrapping.
  always_comb begin
    if (!pc_write_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // While reset is held any in-flight access is dropped at once.
  assign DMem_Valid_o  = dmem_valid_s & rst_i;
  assign Freeze_o      = freeze_s & rst_i;
  assign PCWrite_o     = pc_write_s;
  assign IF_ID_Write_o = if_id_write_s;
  assign ID_EX_NoOp_o  = id_ex_noop_s;
  assign IF_ID_Flush_o = if_id_flush_s;
  assign StallCount_o  = stall_cnt_q;
  assign Timeout_o     = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        EX_MemRead_i;
  logic [4:0]  EX_Rd_i;
  logic [4:0]  ID_Rs1_i;
  logic [4:0]  ID_Rs2_i;
  logic        ID_Rs1Used_i;
  logic        ID_Rs2Used_i;
  logic        ID_BranchTaken_i;
  logic        MEM_Req_i;
  logic        DMem_Ack_i;
  logic        DMem_Valid_o;
  logic        PCWrite_o;
  logic        IF_ID_Write_o;
  logic        ID_EX_NoOp_o;
  logic        IF_ID_Flush_o;
  logic        Freeze_o;
  logic [15:0] StallCount_o;
  logic        Timeout_o;

  int checks   = 0;
  int failures = 0;

  pipeline_stall_controller #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .EX_MemRead_i(EX_MemRead_i), .EX_Rd_i(EX_Rd_i),
    .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i),
    .ID_Rs1Used_i(ID_Rs1Used_i), .ID_Rs2Used_i(ID_Rs2Used_i),
    .ID_BranchTaken_i(ID_BranchTaken_i),
    .MEM_Req_i(MEM_Req_i), .DMem_Ack_i(DMem_Ack_i),
    .DMem_Valid_o(DMem_Valid_o), .PCWrite_o(PCWrite_o),
    .IF_ID_Write_o(IF_ID_Write_o), .ID_EX_NoOp_o(ID_EX_NoOp_o),
    .IF_ID_Flush_o(IF_ID_Flush_o), .Freeze_o(Freeze_o),
    .StallCount_o(StallCount_o), .Timeout_o(Timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    EX_MemRead_i = 1'b0; EX_Rd_i = 5'd0; ID_Rs1_i = 5'd0; ID_Rs2_i = 5'd0;
    ID_Rs1Used_i = 1'b0; ID_Rs2Used_i = 1'b0; ID_BranchTaken_i = 1'b0;
    MEM_Req_i = 1'b0; DMem_Ack_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b0;
    tick(); tick();
    checks++;
    if ({PCWrite_o, IF_ID_Write_o, ID_EX_NoOp_o, IF_ID_Flush_o, Freeze_o, DMem_Valid_o, Timeout_o} !== 7'b1100000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 1100000",
               {PCWrite_o, IF_ID_Write_o, ID_EX_NoOp_o, IF_ID_Flush_o, Freeze_o, DMem_Valid_o, Timeout_o});
    end
    checks++;
    if (StallCount_o !== 16'd0) begin
      failures++; $display("FAIL reset_stallcount: got %0h expected 0", StallCount_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (PCWrite_o !== 1'b1 || Freeze_o !== 1'b0 || StallCount_o !== 16'd0) begin
      failures++;
      $display("FAIL post_reset_idle: got pcw=%b frz=%b cnt=%0h expected 1 0 0", PCWrite_o, Freeze_o, StallCount_o);
    end
  endtask

  task automatic test_load_use();
    EX_MemRead_i = 1'b1; EX_Rd_i = 5'd5; ID_Rs2_i = 5'd5; ID_Rs2Used_i = 1'b0;
    ID_Rs1_i = 5'd6; ID_Rs1Used_i = 1'b1;
    #1;
    checks++;
    if (ID_EX_NoOp_o !== 1'b0 || PCWrite_o !== 1'b1) begin
      failures++; $display("FAIL unused_rs2_no_stall: got noop=%b pcw=%b expected 0 1", ID_EX_NoOp_o, PCWrite_o);
    end
    ID_Rs2Used_i = 1'b1;
    #1;
    checks++;
    if ({ID_EX_NoOp_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o} !== 4'b1000) begin
      failures++;
      $display("FAIL load_use_stall: got %b expected 1000", {ID_EX_NoOp_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o});
    end
    tick();
    checks++;
    if (StallCount_o !== 16'd1) begin
      failures++; $display("FAIL load_use_count: got %0d expected 1", StallCount_o);
    end
    // Destination x0 never creates a hazard.
    EX_Rd_i = 5'd0; ID_Rs1_i = 5'd0; ID_Rs2_i = 5'd0;
    #1;
    checks++;
    if (ID_EX_NoOp_o !== 1'b0 || PCWrite_o !== 1'b1) begin
      failures++; $display("FAIL rd_zero_no_stall: got noop=%b pcw=%b expected 0 1", ID_EX_NoOp_o, PCWrite_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    EX_MemRead_i = 1'b1; EX_Rd_i = 5'd7; ID_Rs1_i = 5'd7; ID_Rs1Used_i = 1'b1;
    ID_BranchTaken_i = 1'b1;
    #1;
    checks++;
    if (IF_ID_Flush_o !== 1'b0 || ID_EX_NoOp_o !== 1'b1) begin
      failures++; $display("FAIL branch_vs_loaduse: got flush=%b noop=%b expected 0 1", IF_ID_Flush_o, ID_EX_NoOp_o);
    end
    tick();
    EX_MemRead_i = 1'b0;
    #1;
    checks++;
    if ({IF_ID_Flush_o, PCWrite_o, IF_ID_Write_o, ID_EX_NoOp_o} !== 4'b1110) begin
      failures++;
      $display("FAIL branch_flush: got %b expected 1110", {IF_ID_Flush_o, PCWrite_o, IF_ID_Write_o, ID_EX_NoOp_o});
    end
    tick();
    checks++;
    if (StallCount_o !== 16'd2) begin
      failures++; $display("FAIL branch_count: got %0d expected 2", StallCount_o);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    // Same-cycle ack: no freeze.
    MEM_Req_i = 1'b1; DMem_Ack_i = 1'b1;
    #1;
    checks++;
    if (DMem_Valid_o !== 1'b1 || Freeze_o !== 1'b0 || PCWrite_o !== 1'b1) begin
      failures++; $display("FAIL mem_fast_ack: got v=%b frz=%b pcw=%b expected 1 0 1", DMem_Valid_o, Freeze_o, PCWrite_o);
    end
    tick();
    // Ack three cycles after the request, branch asserted throughout.
    DMem_Ack_i = 1'b0; ID_BranchTaken_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({Freeze_o, DMem_Valid_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_NoOp_o} !== 6'b110000) begin
        failures++;
        $display("FAIL mem_wait_cycle%0d: got %b expected 110000", i,
                 {Freeze_o, DMem_Valid_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_NoOp_o});
      end
      tick();
    end
    DMem_Ack_i = 1'b1;
    #1;
    checks++;
    if (Freeze_o !== 1'b0 || IF_ID_Flush_o !== 1'b1 || DMem_Valid_o !== 1'b1) begin
      failures++; $display("FAIL mem_ack_cycle: got frz=%b flush=%b v=%b expected 0 1 1", Freeze_o, IF_ID_Flush_o, DMem_Valid_o);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (Freeze_o !== 1'b0 || PCWrite_o !== 1'b1 || StallCount_o !== 16'd5) begin
      failures++; $display("FAIL mem_back_to_run: got frz=%b pcw=%b cnt=%0d expected 0 1 5", Freeze_o, PCWrite_o, StallCount_o);
    end
  endtask

  task automatic test_timeout();
    MEM_Req_i = 1'b1; DMem_Ack_i = 1'b0;
    tick();  // RUN cycle that enters MEM_WAIT
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Timeout_o !== 1'b0 || Freeze_o !== 1'b1) begin
        failures++; $display("FAIL timeout_wait%0d: got to=%b frz=%b expected 0 1", i, Timeout_o, Freeze_o);
      end
      tick();
    end
    DMem_Ack_i = 1'b1;
    #1;
    checks++;
    if ({Timeout_o, Freeze_o, PCWrite_o, DMem_Valid_o} !== 4'b1100) begin
      failures++; $display("FAIL error_state: got %b expected 1100", {Timeout_o, Freeze_o, PCWrite_o, DMem_Valid_o});
    end
    tick();
    checks++;
    if (Timeout_o !== 1'b1 || Freeze_o !== 1'b1 || StallCount_o !== 16'd11) begin
      failures++; $display("FAIL error_sticky: got to=%b frz=%b cnt=%0d expected 1 1 11", Timeout_o, Freeze_o, StallCount_o);
    end
    // Asynchronous reset with the request still held.
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({Timeout_o, Freeze_o, DMem_Valid_o} !== 3'b000 || StallCount_o !== 16'd0) begin
      failures++;
      $display("FAIL async_reset_error: got to=%b frz=%b v=%b cnt=%0d expected 0 0 0 0", Timeout_o, Freeze_o, DMem_Valid_o, StallCount_o);
    end
    tick();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    checks++;
    if (PCWrite_o !== 1'b1 || Freeze_o !== 1'b0 || Timeout_o !== 1'b0) begin
      failures++; $display("FAIL after_error_reset: got pcw=%b frz=%b to=%b expected 1 0 0", PCWrite_o, Freeze_o, Timeout_o);
    end
  endtask

  task automatic test_saturate();
    EX_MemRead_i = 1'b1; EX_Rd_i = 5'd3; ID_Rs1_i = 5'd3; ID_Rs1Used_i = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (StallCount_o !== 16'hFFFE) begin
      failures++; $display("FAIL stall_near_max: got %0h expected fffe", StallCount_o);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (StallCount_o !== 16'hFFFF) begin
      failures++; $display("FAIL stall_saturate: got %0h expected ffff", StallCount_o);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
